iob_plic_mt: RTL

IOB_PLIC_MT -- requirements
Module: iob_plic_mt

---
 rtl/iob_plic_mt.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/iob_plic_mt.sv
`default_nettype none
// ============================================================================
// Module   : iob_plic_mt
// Brief    : Multi-target platform-level interrupt controller on an IOb
//            register interface. Sources are level or edge (counted);
//            each target gets a registered highest-priority pending ID.
// Revision : 1.0 - initial release
// ============================================================================
module iob_plic_mt #(
    parameter int ADDR_W            = 16,
    parameter int DATA_W            = 32,
    parameter int SOURCES           = 8,
    parameter int TARGETS           = 2,
    parameter int PRIORITY_W        = 3,
    parameter int MAX_PENDING_COUNT = 4
) (
    input  logic                  clk_i,
    input  logic                  arst_i_n,
    input  logic                  iob_avalid_i,
    input  logic [ADDR_W-1:0]     iob_addr_i,
    input  logic [DATA_W-1:0]     iob_wdata_i,
    input  logic [DATA_W/8-1:0]   iob_wstrb_i,
    output logic                  iob_ready_o,
    output logic                  iob_rvalid_o,
    output logic [DATA_W-1:0]     iob_rdata_o,
    input  logic [SOURCES-1:0]    src_i,
    output logic [TARGETS-1:0]    irq_o
);

    localparam int ID_W   = $clog2(SOURCES + 1);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = 4;

    // Configuration and per-source state (source IDs index directly, 1..SOURCES)
    logic [SOURCES:1]      r_el;
    logic [SOURCES:1]      r_ip_lvl;
    logic [SOURCES:1]      r_ins;
    logic [SOURCES:1]      r_src_q;
    logic [CNT_W-1:0]      r_cnt  [1:SOURCES];
    logic [PRIORITY_W-1:0] r_prio [1:SOURCES];
    logic [SOURCES:1]      r_ie   [TARGETS];
    logic [PRIORITY_W-1:0] r_th   [TARGETS];
    logic [ID_W-1:0]       r_id   [TARGETS];
    logic [TARGETS-1:0]    r_irq;
    logic                  r_rvalid;
    logic [DATA_W-1:0]     r_rdata;

    logic                  w_rd, w_wr, w_hi;
    logic [1:0]            w_page;
    logic [5:0]            w_idx;
    logic [2:0]            w_tgt;
    logic                  w_sel_el, w_sel_ip, w_sel_prio, w_sel_ie, w_sel_th, w_sel_claim;
    logic [SOURCES:1]      w_src, w_edge, w_ip, w_claim_vec, w_cmp_vec, w_el_new, w_el_chg;
    logic [ID_W-1:0]       w_cid, w_claim_ret;
    logic [ID_W-1:0]       w_arb [TARGETS];
    logic [PRIORITY_W-1:0] w_bp;
    logic [DATA_W-1:0]     w_rdata, w_wmerge;
    logic                  w_unused;

    // Replace the strobed bytes of the current register value with write data
    function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0] old_v,
                                                  input logic [DATA_W-1:0] wd,
                                                  input logic [STRB_W-1:0] st);
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int b = 0; b < STRB_W; b++)
            if (st[b]) res[8*b +: 8] = wd[8*b +: 8];
        return res;
    endfunction

    assign w_rd   = iob_avalid_i && (iob_wstrb_i == '0);
    assign w_wr   = iob_avalid_i && (iob_wstrb_i != '0);
    // Misaligned or out-of-window addresses decode to nothing
    assign w_hi   = ((iob_addr_i >> 10) == '0) && (iob_addr_i[1:0] == 2'b00);
    assign w_page = iob_addr_i[9:8];
    assign w_idx  = iob_addr_i[7:2];
    assign w_tgt  = iob_addr_i[5:3];

    assign w_sel_el    = w_hi && (w_page == 2'd0) && (w_idx == 6'd0);
    assign w_sel_ip    = w_hi && (w_page == 2'd0) && (w_idx == 6'd1);
    assign w_sel_prio  = w_hi && (w_page == 2'd1) && (w_idx != 6'd0) && (32'(w_idx) <= SOURCES);
    assign w_sel_ie    = w_hi && (w_page == 2'd2) && (32'(w_idx) < TARGETS);
    assign w_sel_th    = w_hi && (w_page == 2'd3) && (iob_addr_i[7:6] == 2'b00)
                         && (32'(w_tgt) < TARGETS) && !iob_addr_i[2];
    assign w_sel_claim = w_hi && (w_page == 2'd3) && (iob_addr_i[7:6] == 2'b00)
                         && (32'(w_tgt) < TARGETS) && iob_addr_i[2];

    assign w_src  = src_i;
    assign w_edge = w_src & ~r_src_q;

    // Pending view: edge sources pend while counted and not in service
    always_comb begin
        for (int s = 1; s <= SOURCES; s++)
            w_ip[s] = r_el[s] ? ((r_cnt[s] != '0) && !r_ins[s]) : r_ip_lvl[s];
    end

    // Claim/complete decode; a stale or already-taken ID claims nothing
    always_comb begin
        w_cid       = '0;
        w_claim_vec = '0;
        w_cmp_vec   = '0;
        for (int t = 0; t < TARGETS; t++)
            if (w_tgt == 3'(t)) w_cid = r_id[t];
        for (int s = 1; s <= SOURCES; s++) begin
            w_claim_vec[s] = w_rd && w_sel_claim && (w_cid == ID_W'(s)) && w_ip[s] && !r_ins[s];
            w_cmp_vec[s]   = w_wr && w_sel_claim && (iob_wdata_i == DATA_W'(s)) && r_ins[s];
        end
        w_claim_ret = (w_claim_vec != '0) ? w_cid : '0;
    end

    // Per-target arbitration: strict '>' against a threshold-seeded best keeps the lowest ID on ties
    always_comb begin
        w_bp = '0;
        for (int t = 0; t < TARGETS; t++) begin
            w_arb[t] = '0;
            w_bp     = r_th[t];
            for (int s = 1; s <= SOURCES; s++) begin
                if (w_ip[s] && r_ie[t][s] && (r_prio[s] > w_bp)) begin
                    w_bp     = r_prio[s];
                    w_arb[t] = ID_W'(s);
                end
            end
        end
    end

    // Read mux; also supplies the old value for byte-strobe merging on writes
    always_comb begin
        w_rdata = '0;
        if (w_sel_el)    w_rdata = DATA_W'({r_el, 1'b0});
        if (w_sel_ip)    w_rdata = DATA_W'({w_ip, 1'b0});
        if (w_sel_claim) w_rdata = DATA_W'(w_claim_ret);
        for (int s = 1; s <= SOURCES; s++)
            if (w_sel_prio && (w_idx == 6'(s))) w_rdata = DATA_W'(r_prio[s]);
        for (int t = 0; t < TARGETS; t++) begin
            if (w_sel_ie && (w_idx == 6'(t))) w_rdata = DATA_W'({r_ie[t], 1'b0});
            if (w_sel_th && (w_tgt == 3'(t))) w_rdata = DATA_W'(r_th[t]);
        end
    end

    assign w_wmerge = f_merge(w_rdata, iob_wdata_i, iob_wstrb_i);
    assign w_el_new = w_wmerge[SOURCES:1];
    assign w_el_chg = (w_wr && w_sel_el) ? (w_el_new ^ r_el) : '0;
    assign w_unused = ^w_wmerge;

    // Software-visible configuration registers
    always_ff @(posedge clk_i or negedge arst_i_n) begin
        if (!arst_i_n) begin
            r_el <= '0;
            for (int s = 1; s <= SOURCES; s++) r_prio[s] <= '0;
            for (int t = 0; t < TARGETS; t++) begin
                r_ie[t] <= '0;
                r_th[t] <= '0;
            end
        end else if (w_wr) begin
            if (w_sel_el) r_el <= w_el_new;
            for (int s = 1; s <= SOURCES; s++)
                if (w_sel_prio && (w_idx == 6'(s))) r_prio[s] <= w_wmerge[PRIORITY_W-1:0];
            for (int t = 0; t < TARGETS; t++) begin
                if (w_sel_ie && (w_idx == 6'(t))) r_ie[t] <= w_wmerge[SOURCES:1];
                if (w_sel_th && (w_tgt == 3'(t))) r_th[t] <= w_wmerge[PRIORITY_W-1:0];
            end
        end
    end

    // Gateway state: level pending, edge counters, in-service flags
    always_ff @(posedge clk_i or negedge arst_i_n) begin
        if (!arst_i_n) begin
            r_src_q  <= '0;
            r_ip_lvl <= '0;
            r_ins    <= '0;
            for (int s = 1; s <= SOURCES; s++) r_cnt[s] <= '0;
        end else begin
            r_src_q <= w_src;
            for (int s = 1; s <= SOURCES; s++) begin
                if (w_el_chg[s]) begin
                    r_ip_lvl[s] <= 1'b0;
                    r_ins[s]    <= 1'b0;
                    r_cnt[s]    <= '0;
                end else begin
                    if (w_claim_vec[s])    r_ins[s] <= 1'b1;
                    else if (w_cmp_vec[s]) r_ins[s] <= 1'b0;
                    // A completing level source may re-pend in the same edge
                    if (r_el[s] || w_claim_vec[s])
                        r_ip_lvl[s] <= 1'b0;
                    else if (w_src[s] && (!r_ins[s] || w_cmp_vec[s]))
                        r_ip_lvl[s] <= 1'b1;
                    if (r_el[s]) begin
                        if (w_edge[s] && !w_claim_vec[s] && (r_cnt[s] < CNT_W'(MAX_PENDING_COUNT)))
                            r_cnt[s] <= r_cnt[s] + CNT_W'(1);
                        else if (w_claim_vec[s] && !w_edge[s] && (r_cnt[s] != '0))
                            r_cnt[s] <= r_cnt[s] - CNT_W'(1);
                    end
                end
            end
        end
    end

    // Registered arbiter result and interrupt lines
    always_ff @(posedge clk_i or negedge arst_i_n) begin
        if (!arst_i_n) begin
            r_irq <= '0;
            for (int t = 0; t < TARGETS; t++) r_id[t] <= '0;
        end else begin
            for (int t = 0; t < TARGETS; t++) begin
                r_id[t]  <= w_arb[t];
                r_irq[t] <= (w_arb[t] != '0);
            end
        end
    end

    // One-cycle read response
    always_ff @(posedge clk_i or negedge arst_i_n) begin
        if (!arst_i_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) r_rdata <= w_rdata;
        end
    end

    assign iob_ready_o  = 1'b1;
    assign iob_rvalid_o = r_rvalid;
    assign iob_rdata_o  = r_rdata;
    assign irq_o        = r_irq;

endmodule
`default_nettype wire
